// File: rtl/cpu_pkg.sv
// Shared encodings for the single-cycle MIPS-subset core: opcodes, functs,
// ALU operation enum and a sign-extension helper.
package cpu_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_SLTI  = 6'b001010;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;

  localparam logic [5:0] FUNCT_ADD = 6'b100000;
  localparam logic [5:0] FUNCT_SUB = 6'b100010;
  localparam logic [5:0] FUNCT_AND = 6'b100100;
  localparam logic [5:0] FUNCT_OR  = 6'b100101;
  localparam logic [5:0] FUNCT_SLT = 6'b101010;

  typedef enum logic [2:0] {
    ALU_ADD,
    ALU_SUB,
    ALU_AND,
    ALU_OR,
    ALU_SLT
  } alu_op_e;

  function automatic logic [31:0] sign_ext16(input logic [15:0] imm);
    return {{16{imm[15]}}, imm};
  endfunction

endpackage

// File: rtl/simple_single_cpu_alu.sv
// 32-bit ALU: wrap-around add/sub, bitwise and/or, signed set-less-than.
module simple_single_cpu_alu
  import cpu_pkg::*;
(
  input  logic [31:0] a_i,
  input  logic [31:0] b_i,
  input  alu_op_e     op_i,
  output logic [31:0] result_o,
  output logic        zero_o
);

  always_comb begin
    result_o = '0;
    case (op_i)
      ALU_ADD: result_o = a_i + b_i;
      ALU_SUB: result_o = a_i - b_i;
      ALU_AND: result_o = a_i & b_i;
      ALU_OR:  result_o = a_i | b_i;
      ALU_SLT: result_o = {31'b0, ($signed(a_i) < $signed(b_i))};
      default: result_o = '0;
    endcase
  end

  assign zero_o = (result_o == '0);

endmodule

// File: rtl/simple_single_cpu_im.sv
// Combinational instruction ROM; contents are loaded from outside through
// the Instr_Mem array, and the byte address wraps modulo the depth.
module simple_single_cpu_im #(
  parameter int unsigned IMEM_DEPTH = 32
) (
  input  logic [31:0] addr_i,
  output logic [31:0] instr_o
);

  localparam int unsigned AW = (IMEM_DEPTH > 1) ? $clog2(IMEM_DEPTH) : 1;

  logic [31:0] Instr_Mem [0:IMEM_DEPTH-1];
  logic [31:0] word_idx;
  logic        unused_idx_hi;

  assign word_idx      = (addr_i >> 2) % IMEM_DEPTH;
  assign instr_o       = Instr_Mem[word_idx[AW-1:0]];
  assign unused_idx_hi = ^word_idx[31:AW];

endmodule

// File: rtl/simple_single_cpu_rf.sv
// 32x32 register file: two combinational read ports, one clocked write port,
// r0 hard-wired to zero, synchronous clear on reset.
module simple_single_cpu_rf (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [4:0]  rs_addr_i,
  input  logic [4:0]  rt_addr_i,
  input  logic        we_i,
  input  logic [4:0]  wr_addr_i,
  input  logic [31:0] wr_data_i,
  output logic [31:0] rs_data_o,
  output logic [31:0] rt_data_o
);

  logic [31:0] Reg_File [0:31];

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int unsigned i = 0; i < 32; i++) begin
        Reg_File[5'(i)] <= '0;
      end
    end else if (we_i && (wr_addr_i != '0)) begin
      Reg_File[wr_addr_i] <= wr_data_i;
    end
  end

  assign rs_data_o = (rs_addr_i == '0) ? '0 : Reg_File[rs_addr_i];
  assign rt_data_o = (rt_addr_i == '0) ? '0 : Reg_File[rt_addr_i];

endmodule

// File: rtl/simple_single_cpu.sv
// Single-cycle MIPS-subset CPU: fetch, decode, execute and retire one
// instruction per rising edge. Decoder, PC and branch logic live here.
module simple_single_cpu
  import cpu_pkg::*;
#(
  parameter int unsigned IMEM_DEPTH = 32,
  parameter logic [31:0] RESET_PC   = '0
) (
  input  logic clk_i,
  input  logic rst_i
);

  logic [31:0] pc_q, pc_d;
  logic [31:0] pc_plus4, branch_target;
  logic [31:0] instr;
  logic [5:0]  opcode, funct;
  logic [4:0]  rs, rt, rd;
  logic [31:0] imm_ext;
  logic [31:0] rs_data, rt_data;
  logic [31:0] alu_b, alu_result;
  logic        alu_zero;
  alu_op_e     alu_op;
  logic        reg_we, use_imm, is_beq, is_bne, branch_taken;
  logic [4:0]  wr_addr;
  logic        unused_shamt;

  simple_single_cpu_im #(
    .IMEM_DEPTH(IMEM_DEPTH)
  ) IM (
    .addr_i (pc_q),
    .instr_o(instr)
  );

  assign opcode       = instr[31:26];
  assign rs           = instr[25:21];
  assign rt           = instr[20:16];
  assign rd           = instr[15:11];
  assign funct        = instr[5:0];
  assign imm_ext      = sign_ext16(instr[15:0]);
  assign unused_shamt = ^instr[10:6];

  // Unsupported opcodes/functs fall through with reg_we=0 and no branch,
  // which makes them behave as NOPs.
  always_comb begin
    reg_we  = 1'b0;
    alu_op  = ALU_ADD;
    use_imm = 1'b0;
    wr_addr = rd;
    is_beq  = 1'b0;
    is_bne  = 1'b0;
    case (opcode)
      OP_RTYPE: begin
        case (funct)
          FUNCT_ADD: begin alu_op = ALU_ADD; reg_we = 1'b1; end
          FUNCT_SUB: begin alu_op = ALU_SUB; reg_we = 1'b1; end
          FUNCT_AND: begin alu_op = ALU_AND; reg_we = 1'b1; end
          FUNCT_OR:  begin alu_op = ALU_OR;  reg_we = 1'b1; end
          FUNCT_SLT: begin alu_op = ALU_SLT; reg_we = 1'b1; end
          default: ;
        endcase
      end
      OP_ADDI: begin
        alu_op  = ALU_ADD;
        use_imm = 1'b1;
        wr_addr = rt;
        reg_we  = 1'b1;
      end
      OP_SLTI: begin
        alu_op  = ALU_SLT;
        use_imm = 1'b1;
        wr_addr = rt;
        reg_we  = 1'b1;
      end
      OP_BEQ: begin
        alu_op = ALU_SUB;
        is_beq = 1'b1;
      end
      OP_BNE: begin
        alu_op = ALU_SUB;
        is_bne = 1'b1;
      end
      default: ;
    endcase
  end

  simple_single_cpu_rf RF (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .rs_addr_i(rs),
    .rt_addr_i(rt),
    .we_i     (reg_we),
    .wr_addr_i(wr_addr),
    .wr_data_i(alu_result),
    .rs_data_o(rs_data),
    .rt_data_o(rt_data)
  );

  assign alu_b = use_imm ? imm_ext : rt_data;

  simple_single_cpu_alu ALU (
    .a_i     (rs_data),
    .b_i     (alu_b),
    .op_i    (alu_op),
    .result_o(alu_result),
    .zero_o  (alu_zero)
  );

  assign pc_plus4      = pc_q + 32'd4;
  assign branch_target = pc_plus4 + (imm_ext << 2);
  assign branch_taken  = (is_beq & alu_zero) | (is_bne & ~alu_zero);
  assign pc_d          = branch_taken ? branch_target : pc_plus4;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      pc_q <= RESET_PC;
    end else begin
      pc_q <= pc_d;
    end
  end

endmodule

// File: tb/tb_simple_single_cpu.sv
// Bench for simple_single_cpu: directed program table, a mid-run reset
// sequence, and random programs checked against an instruction-level model.
module tb_simple_single_cpu;

  localparam logic [5:0] T_RTYPE = 6'b000000, T_ADDI = 6'b001000, T_SLTI = 6'b001010;
  localparam logic [5:0] T_BEQ   = 6'b000100, T_BNE  = 6'b000101;
  localparam logic [5:0] T_ADD = 6'b100000, T_SUB = 6'b100010, T_AND = 6'b100100;
  localparam logic [5:0] T_OR  = 6'b100101, T_SLT = 6'b101010;

  logic clk = 1'b0;
  logic rst_i = 1'b1;
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  simple_single_cpu #(
    .IMEM_DEPTH(32),
    .RESET_PC  (32'd0)
  ) dut (
    .clk_i(clk),
    .rst_i(rst_i)
  );

  typedef struct packed {
    logic [7:0][31:0] prog;
    logic [3:0]       n;
    logic [7:0]       cycles;
    logic [31:0]      exp_pc;
    logic [2:0]       nchk;
    logic [5:0][4:0]  chk_reg;
    logic [5:0][31:0] chk_val;
  } vec_t;

  vec_t        vecs [8];
  logic [31:0] m_rom [32];
  logic [31:0] m_reg [32];
  logic [31:0] m_pc;

  function automatic logic [31:0] enc_r(input logic [5:0] f, input int rd, input int rs, input int rt);
    return {T_RTYPE, 5'(rs), 5'(rt), 5'(rd), 5'b0, f};
  endfunction

  function automatic logic [31:0] enc_i(input logic [5:0] op, input int rt, input int rs, input int imm);
    return {op, 5'(rs), 5'(rt), 16'(imm)};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic load_rom();
    for (int i = 0; i < 32; i++) dut.IM.Instr_Mem[5'(i)] = m_rom[i];
  endtask

  function automatic int count_nonzero_regs();
    int nz = 0;
    for (int i = 0; i < 32; i++) if (dut.RF.Reg_File[5'(i)] !== 32'd0) nz++;
    return nz;
  endfunction

  // Reference model: interpret one instruction from the bench's ROM copy.
  task automatic m_reset();
    m_pc = 32'd0;
    for (int i = 0; i < 32; i++) m_reg[i] = 32'd0;
  endtask

  task automatic m_step();
    logic [31:0] ins, a, b, se, npc, res;
    int          dst;
    ins = m_rom[int'((m_pc >> 2) % 32)];
    a   = m_reg[int'(ins[25:21])];
    b   = m_reg[int'(ins[20:16])];
    se  = {{16{ins[15]}}, ins[15:0]};
    npc = m_pc + 32'd4;
    dst = -1;
    res = 32'd0;
    case (ins[31:26])
      T_RTYPE: begin
        dst = int'(ins[15:11]);
        case (ins[5:0])
          T_ADD: res = a + b;
          T_SUB: res = a - b;
          T_AND: res = a & b;
          T_OR:  res = a | b;
          T_SLT: res = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
          default: dst = -1;
        endcase
      end
      T_ADDI: begin dst = int'(ins[20:16]); res = a + se; end
      T_SLTI: begin dst = int'(ins[20:16]); res = ($signed(a) < $signed(se)) ? 32'd1 : 32'd0; end
      T_BEQ:  if (a == b) npc = m_pc + 32'd4 + se * 4;
      T_BNE:  if (a != b) npc = m_pc + 32'd4 + se * 4;
      default: ;
    endcase
    if (dst > 0) m_reg[dst] = res;
    m_pc = npc;
  endtask

  function automatic logic [31:0] rand_instr();
    int rs = $urandom_range(0, 7);
    int rt = $urandom_range(0, 7);
    int rd = $urandom_range(0, 7);
    int imm;
    case ($urandom_range(0, 9))
      0: return enc_r(T_ADD, rd, rs, rt);
      1: return enc_r(T_SUB, rd, rs, rt);
      2: return enc_r(T_AND, rd, rs, rt);
      3: return enc_r(T_OR,  rd, rs, rt);
      4: return enc_r(T_SLT, rd, rs, rt);
      5: return enc_i(T_ADDI, rt, rs, int'($urandom_range(0, 65535)));
      6: return enc_i(T_SLTI, rt, rs, int'($urandom_range(0, 65535)));
      7, 8: begin
        imm = int'($urandom_range(0, 7)) - 3;
        if (imm == -1) imm = 2;
        return enc_i(($urandom_range(0, 1) == 0) ? T_BEQ : T_BNE, rt, rs, imm);
      end
      default: return $urandom;
    endcase
  endfunction

  task automatic set_chk(input int v, input int k, input int r, input logic [31:0] val);
    vecs[v].chk_reg[k] = 5'(r);
    vecs[v].chk_val[k] = val;
  endtask

  initial begin
    for (int v = 0; v < 8; v++) vecs[v] = '0;

    // immediates
    vecs[0].prog[0] = enc_i(T_ADDI, 1, 0, 5);
    vecs[0].prog[1] = enc_i(T_ADDI, 2, 0, -3);
    vecs[0].prog[2] = enc_i(T_SLTI, 3, 2, 0);
    vecs[0].n = 3; vecs[0].cycles = 3; vecs[0].exp_pc = 12; vecs[0].nchk = 3;
    set_chk(0, 0, 1, 32'd5); set_chk(0, 1, 2, 32'hFFFF_FFFD); set_chk(0, 2, 3, 32'd1);

    // R-type
    vecs[1].prog[0] = enc_i(T_ADDI, 1, 0, 5);
    vecs[1].prog[1] = enc_i(T_ADDI, 2, 0, -3);
    vecs[1].prog[2] = enc_r(T_ADD, 4, 1, 2);
    vecs[1].prog[3] = enc_r(T_SUB, 5, 1, 2);
    vecs[1].prog[4] = enc_r(T_AND, 6, 1, 2);
    vecs[1].prog[5] = enc_r(T_OR,  7, 1, 2);
    vecs[1].prog[6] = enc_r(T_SLT, 8, 2, 1);
    vecs[1].n = 7; vecs[1].cycles = 7; vecs[1].exp_pc = 28; vecs[1].nchk = 5;
    set_chk(1, 0, 4, 32'd2); set_chk(1, 1, 5, 32'd8); set_chk(1, 2, 6, 32'd5);
    set_chk(1, 3, 7, 32'hFFFF_FFFD); set_chk(1, 4, 8, 32'd1);

    // bne taken skips one instruction
    vecs[2].prog[0] = enc_i(T_ADDI, 1, 0, 1);
    vecs[2].prog[1] = enc_i(T_BNE, 0, 1, 1);
    vecs[2].prog[2] = enc_i(T_ADDI, 2, 0, 9);
    vecs[2].prog[3] = enc_i(T_ADDI, 3, 0, 7);
    vecs[2].n = 4; vecs[2].cycles = 5; vecs[2].exp_pc = 24; vecs[2].nchk = 3;
    set_chk(2, 0, 1, 32'd1); set_chk(2, 1, 2, 32'd0); set_chk(2, 2, 3, 32'd7);

    // beq not taken falls through
    vecs[3] = vecs[2];
    vecs[3].prog[1] = enc_i(T_BEQ, 0, 1, 1);
    vecs[3].exp_pc = 20;
    set_chk(3, 1, 2, 32'd9);

    // r0 protection
    vecs[4].prog[0] = enc_i(T_ADDI, 0, 0, 4);
    vecs[4].prog[1] = enc_r(T_ADD, 9, 0, 0);
    vecs[4].n = 2; vecs[4].cycles = 2; vecs[4].exp_pc = 8; vecs[4].nchk = 2;
    set_chk(4, 0, 0, 32'd0); set_chk(4, 1, 9, 32'd0);

    // beq with imm=-1 spins on itself
    vecs[5].prog[0] = enc_i(T_ADDI, 1, 0, 1);
    vecs[5].prog[1] = enc_i(T_BEQ, 0, 0, -1);
    vecs[5].prog[2] = enc_i(T_ADDI, 2, 0, 9);
    vecs[5].n = 3; vecs[5].cycles = 6; vecs[5].exp_pc = 4; vecs[5].nchk = 2;
    set_chk(5, 0, 1, 32'd1); set_chk(5, 1, 2, 32'd0);

    // signed compares, wrap-around, unknown opcode and funct
    vecs[6].prog[0] = enc_i(T_ADDI, 1, 0, -1);
    vecs[6].prog[1] = enc_i(T_SLTI, 2, 1, 1);
    vecs[6].prog[2] = enc_r(T_SLT, 3, 0, 1);
    vecs[6].prog[3] = enc_r(T_SUB, 4, 0, 1);
    vecs[6].prog[4] = enc_r(T_ADD, 5, 1, 1);
    vecs[6].prog[5] = {6'b111111, 5'd1, 5'd7, 16'h0005};
    vecs[6].prog[6] = enc_r(6'b000000, 7, 1, 1);
    vecs[6].n = 7; vecs[6].cycles = 7; vecs[6].exp_pc = 28; vecs[6].nchk = 6;
    set_chk(6, 0, 1, 32'hFFFF_FFFF); set_chk(6, 1, 2, 32'd1); set_chk(6, 2, 3, 32'd0);
    set_chk(6, 3, 4, 32'd1); set_chk(6, 4, 5, 32'hFFFF_FFFE); set_chk(6, 5, 7, 32'd0);

    // branch to byte 136 fetches word 34 mod 32 = 2
    vecs[7].prog[0] = enc_i(T_ADDI, 1, 0, 1);
    vecs[7].prog[1] = enc_i(T_BNE, 0, 1, 32);
    vecs[7].prog[2] = enc_i(T_ADDI, 2, 0, 9);
    vecs[7].prog[3] = enc_i(T_ADDI, 3, 0, 7);
    vecs[7].n = 4; vecs[7].cycles = 4; vecs[7].exp_pc = 144; vecs[7].nchk = 3;
    set_chk(7, 0, 1, 32'd1); set_chk(7, 1, 2, 32'd9); set_chk(7, 2, 3, 32'd7);

    for (int v = 0; v < 8; v++) begin
      rst_i = 1'b1;
      for (int i = 0; i < 32; i++) m_rom[i] = (i < int'(vecs[v].n)) ? vecs[v].prog[i] : 32'd0;
      load_rom();
      step();
      step();
      check($sformatf("v%0d reset pc", v), dut.pc_q, 32'd0);
      check($sformatf("v%0d reset nonzero regs", v), 32'(count_nonzero_regs()), 32'd0);
      rst_i = 1'b0;
      for (int c = 0; c < int'(vecs[v].cycles); c++) step();
      check($sformatf("v%0d pc", v), dut.pc_q, vecs[v].exp_pc);
      for (int k = 0; k < int'(vecs[v].nchk); k++)
        check($sformatf("v%0d r%0d", v, vecs[v].chk_reg[k]),
              dut.RF.Reg_File[vecs[v].chk_reg[k]], vecs[v].chk_val[k]);
    end

    // reset after two retired instructions, then re-run from word 0
    rst_i = 1'b1;
    for (int i = 0; i < 32; i++) m_rom[i] = (i < 3) ? vecs[0].prog[i] : 32'd0;
    load_rom();
    step();
    rst_i = 1'b0;
    step();
    step();
    check("mid pre-reset pc", dut.pc_q, 32'd8);
    check("mid pre-reset r2", dut.RF.Reg_File[2], 32'hFFFF_FFFD);
    rst_i = 1'b1;
    step();
    rst_i = 1'b0;
    check("mid reset pc", dut.pc_q, 32'd0);
    check("mid reset nonzero regs", 32'(count_nonzero_regs()), 32'd0);
    step();
    check("mid first retire pc", dut.pc_q, 32'd4);
    check("mid first retire r1", dut.RF.Reg_File[1], 32'd5);
    check("mid first retire r2", dut.RF.Reg_File[2], 32'd0);
    step();
    step();
    check("mid rerun r2", dut.RF.Reg_File[2], 32'hFFFF_FFFD);
    check("mid rerun r3", dut.RF.Reg_File[3], 32'd1);

    // random programs against the model, one with a reset mid-run
    for (int p = 0; p < 4; p++) begin
      rst_i = 1'b1;
      for (int i = 0; i < 32; i++) m_rom[i] = rand_instr();
      load_rom();
      step();
      step();
      m_reset();
      rst_i = 1'b0;
      for (int c = 0; c < 200; c++) begin
        int bad;
        if (p == 1 && c == 90) rst_i = 1'b1;
        step();
        if (rst_i) m_reset();
        else m_step();
        rst_i = 1'b0;
        check($sformatf("rand p%0d c%0d pc", p, c), dut.pc_q, m_pc);
        bad = 0;
        for (int i = 31; i >= 0; i--) if (dut.RF.Reg_File[5'(i)] !== m_reg[i]) bad = i;
        check($sformatf("rand p%0d c%0d r%0d", p, c, bad), dut.RF.Reg_File[5'(bad)], m_reg[bad]);
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
